// File: rtl/conv_mul_share_arb_if.sv
// Handshake bundle between NUM_REQ operand requesters and the shared signed multiplier.
// master = requester/consumer side, slave = the arbitrated multiplier.
interface conv_mul_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [8*NUM_REQ-1:0]  req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic signed [23:0]    res_p;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p
  );
endinterface

// File: rtl/conv_mul_share_arb.sv
// Round-robin arbiter feeding one 8x16 signed multiplier through a 2-stage elastic pipeline.
// Optional macro CONV_MUL_SHARE_ARB_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module conv_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  conv_mul_share_arb_if.slave   bus
`ifdef CONV_MUL_SHARE_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;

  function automatic logic signed [PROD_W-1:0] mul_full(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [COEF_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ID_W-1:0]                r_ptr;
  logic                           w_adv1, w_adv2;
  logic                           w_found, w_grant;
  logic [ID_W-1:0]                w_gnt_idx, w_ptr_nxt;
  logic signed [DATA_W-1:0]       w_a_sel;
  logic signed [COEF_W-1:0]       w_b_sel;

  logic signed [DATA_W-1:0]       r_a_p1;
  logic signed [COEF_W-1:0]       r_b_p1;
  logic [ID_W-1:0]                r_id_p1;
  logic                           r_vld_p1;
  logic signed [PROD_W-1:0]       r_p_p2;
  logic [ID_W-1:0]                r_id_p2;
  logic                           r_vld_p2;

  assign w_adv2 = !r_vld_p2 || bus.res_ready;
  assign w_adv1 = !r_vld_p1 || w_adv2;

  // Two passes: indices at/after the pointer first, then the wrapped-around low indices.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_a_sel   = '0;
    w_b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i >= int'(r_ptr) && bus.req_valid[i]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req_valid[i]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a_sel = bus.req_a[i*DATA_W +: DATA_W];
        w_b_sel = bus.req_b[i*COEF_W +: COEF_W];
      end
    end
  end

  assign w_grant       = w_found && w_adv1 && !ap_rst;
  assign w_ptr_nxt     = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  assign bus.req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_ptr    <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_p_p2   <= '0;
      r_id_p2  <= '0;
    end else begin
      if (w_grant) r_ptr <= w_ptr_nxt;
      if (w_adv1) r_vld_p1 <= w_grant;
      // Stage p1 -> p2 boundary: full-width product, no truncation.
      if (w_adv2) begin
        r_vld_p2 <= r_vld_p1;
        r_p_p2   <= mul_full(r_a_p1, r_b_p1);
        r_id_p2  <= r_id_p1;
      end
    end
  end

  // Input -> p1 boundary: operand registers only load on an actual transfer.
  always_ff @(posedge ap_clk) begin
    if (w_grant) begin
      r_a_p1  <= w_a_sel;
      r_b_p1  <= w_b_sel;
      r_id_p1 <= w_gnt_idx;
    end
  end

  assign bus.res_valid = r_vld_p2;
  assign bus.res_p     = r_p_p2;
  assign bus.res_id    = r_id_p2;

`ifdef CONV_MUL_SHARE_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      r_stall_cnt <= '0;
    else if (|bus.req_valid && !w_grant)
      r_stall_cnt <= sat_inc16(r_stall_cnt);
  end

  assign stall_cnt = r_stall_cnt;
`endif
endmodule
